// File: rtl/sram_burst_ctrl_if.sv
// Host-side bus bundle for sram_burst_ctrl: command, write-data and read-data
// channels (all valid/ready) plus the busy indication.
// The slave modport is the controller's view; the master modport belongs to
// the client that issues bursts.
interface sram_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    logic                  busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst sequencer in front of a single-port synchronous SRAM.
// Accepts read/write burst commands, streams write words straight onto the
// SRAM pins, and returns read words through a 2-entry FIFO whose head is the
// registered read output.
// Optional build macro SRAM_BURST_CTRL_PERF_EN adds saturating word counters
// perf_wr_words / perf_rd_words.
module sram_burst_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_burst_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe
`ifdef SRAM_BURST_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_wr_words,
    output logic [31:0]           perf_rd_words
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH:0]  CNT_ONE  = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH:0]  CNT_ZERO = {(LEN_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_alive;        // 0 only in the first cycle after reset
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH:0]    r_count;        // words still to write / issue

    // Read pipeline: one outstanding SRAM access plus a 2-entry FIFO.
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_head_valid;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_last;
    logic                  r_tail_valid;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_tail_last;

    logic                  w_hv_nxt;
    logic [DATA_WIDTH-1:0] w_hd_nxt;
    logic                  w_hl_nxt;
    logic                  w_tv_nxt;
    logic [DATA_WIDTH-1:0] w_td_nxt;
    logic                  w_tl_nxt;

    logic                  w_cmd_fire;
    logic                  w_wr_fire;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic                  w_issue;
    logic                  w_count_is_one;
    logic                  w_fifo_empty;
    logic                  w_cs;
    logic                  w_we;
    logic                  w_oe;
    logic                  w_drive;

    assign w_count_is_one = (r_count == CNT_ONE);
    assign w_cmd_fire     = (r_state == ST_IDLE) && r_alive && bus.cmd_valid;
    assign w_wr_fire      = (r_state == ST_WRITE) && bus.wr_valid;
    assign w_pop          = r_head_valid && bus.rd_ready;
    assign w_fifo_empty   = !r_head_valid && !r_tail_valid;

    // Occupancy seen by the next capture: current entries plus the access in
    // flight, minus the word leaving this cycle. Counting the pop is what lets
    // a continuously-ready consumer sustain one word per cycle.
    assign w_occ   = {1'b0, r_head_valid} + {1'b0, r_tail_valid}
                   + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = (r_state == ST_READ) && (r_count != CNT_ZERO) && (w_occ < 2'd2);

    // Next-state and SRAM pin decode
    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_oe        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = bus.cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_cs = bus.wr_valid;
                w_we = bus.wr_valid;
                if (w_wr_fire && w_count_is_one) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                w_cs = 1'b1;
                w_oe = 1'b1;
                if (w_issue && w_count_is_one) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                w_cs = 1'b1;
                w_oe = 1'b1;
                if (w_fifo_empty && !r_inflight) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO next contents: pop shifts tail into head, then a capture lands in
    // the first free slot
    always_comb begin
        w_hv_nxt = r_head_valid;
        w_hd_nxt = r_head_data;
        w_hl_nxt = r_head_last;
        w_tv_nxt = r_tail_valid;
        w_td_nxt = r_tail_data;
        w_tl_nxt = r_tail_last;
        if (w_pop) begin
            w_hv_nxt = r_tail_valid;
            w_hd_nxt = r_tail_data;
            w_hl_nxt = r_tail_last;
            w_tv_nxt = 1'b0;
            w_tl_nxt = 1'b0;
        end else begin
            w_tv_nxt = r_tail_valid;
        end
        if (r_inflight) begin
            if (!w_hv_nxt) begin
                w_hv_nxt = 1'b1;
                w_hd_nxt = sram_data;
                w_hl_nxt = r_inflight_last;
            end else begin
                w_tv_nxt = 1'b1;
                w_td_nxt = sram_data;
                w_tl_nxt = r_inflight_last;
            end
        end else begin
            w_tv_nxt = w_tv_nxt;
        end
    end

    // State register and out-of-reset flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // Burst address and remaining-word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_count <= CNT_ZERO;
        end else if (w_cmd_fire) begin
            r_addr  <= bus.cmd_addr;
            r_count <= {1'b0, bus.cmd_len} + CNT_ONE;
        end else if (w_wr_fire || w_issue) begin
            r_addr  <= r_addr + ADDR_ONE;   // wraps modulo 2^ADDR_WIDTH
            r_count <= r_count - CNT_ONE;
        end else begin
            r_addr  <= r_addr;
            r_count <= r_count;
        end
    end

    // In-flight read tracking and 2-entry read FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_head_valid    <= 1'b0;
            r_head_data     <= {DATA_WIDTH{1'b0}};
            r_head_last     <= 1'b0;
            r_tail_valid    <= 1'b0;
            r_tail_data     <= {DATA_WIDTH{1'b0}};
            r_tail_last     <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_count_is_one;
            r_head_valid    <= w_hv_nxt;
            r_head_data     <= w_hd_nxt;
            r_head_last     <= w_hl_nxt;
            r_tail_valid    <= w_tv_nxt;
            r_tail_data     <= w_td_nxt;
            r_tail_last     <= w_tl_nxt;
        end
    end

    // Data bus is driven only during an actual write cycle, so it is always
    // released whenever output enable is asserted.
    assign w_drive   = w_cs && w_we;
    assign sram_data = w_drive ? bus.wr_data : {DATA_WIDTH{1'bz}};

    assign sram_addr = r_addr;
    assign sram_cs   = w_cs;
    assign sram_we   = w_we;
    assign sram_oe   = w_oe;

    assign bus.cmd_ready = (r_state == ST_IDLE) && r_alive;
    assign bus.wr_ready  = (r_state == ST_WRITE);
    assign bus.rd_valid  = r_head_valid;
    assign bus.rd_data   = r_head_data;
    assign bus.rd_last   = r_head_valid && r_head_last;
    assign bus.busy      = (r_state != ST_IDLE);

`ifdef SRAM_BURST_CTRL_PERF_EN
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_rd;

    // Saturating counters of SRAM write cycles and read-word handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_wr <= 32'd0;
            r_perf_rd <= 32'd0;
        end else begin
            if (w_drive && (r_perf_wr != 32'hFFFF_FFFF)) begin
                r_perf_wr <= r_perf_wr + 32'd1;
            end else begin
                r_perf_wr <= r_perf_wr;
            end
            if (w_pop && (r_perf_rd != 32'hFFFF_FFFF)) begin
                r_perf_rd <= r_perf_rd + 32'd1;
            end else begin
                r_perf_rd <= r_perf_rd;
            end
        end
    end

    assign perf_wr_words = r_perf_wr;
    assign perf_rd_words = r_perf_rd;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: a behavioural synchronous SRAM on
// the pins, a reference memory updated from accepted write words, and
// directed plus randomized bursts checked word by word.
module tb_sram_burst_ctrl;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus_if ();

    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_addr;
    logic          sram_cs;
    logic          sram_we;
    logic          sram_oe;
`ifdef SRAM_BURST_CTRL_PERF_EN
    logic [31:0]   perf_wr_words;
    logic [31:0]   perf_rd_words;
`endif

    sram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_oe   (sram_oe)
`ifdef SRAM_BURST_CTRL_PERF_EN
        ,
        .perf_wr_words (perf_wr_words),
        .perf_rd_words (perf_rd_words)
`endif
    );

    // Behavioural SRAM: write at the edge, read word presented the next cycle
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] sram_q;
    logic          sram_q_en;
    always @(posedge clk) begin
        if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_data;
        sram_q_en <= sram_cs && !sram_we && sram_oe;
        if (sram_cs && !sram_we) sram_q <= sram_mem[sram_addr];
    end
    assign sram_data = (sram_q_en && sram_oe) ? sram_q : {DW{1'bz}};

    // Reference memory: what the SRAM must hold after every accepted write
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] wq [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // gap_mode: 0 = wr_valid always, 1 = every other cycle, 2 = random
    task automatic do_write(input logic [AW-1:0] addr, input int n, input int gap_mode,
                            input string tag);
        int idx = 0;
        int cyc = 0;
        int cs_cnt = 0;
        logic v;
        logic [AW-1:0] ea;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = LW'(n - 1);
        #1;
        chk({tag, "_cmd_ready"}, {31'd0, bus_if.cmd_ready}, 32'd1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        while (idx < n && cyc < 4000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus_if.wr_valid = v;
            bus_if.wr_data  = wq[idx];
            #1;
            if (sram_cs) cs_cnt++;
            if (v && bus_if.wr_ready) begin
                ea = addr + AW'(idx);
                chk({tag, "_wr_addr"}, {16'd0, sram_addr}, {16'd0, ea});
                ref_mem[ea] = wq[idx];
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus_if.wr_valid = 1'b0;
        chk({tag, "_wr_words"}, idx, n);
        chk({tag, "_cs_cycles"}, cs_cnt, n);
        #1;
        chk({tag, "_busy_after"}, {31'd0, bus_if.busy}, 32'd0);
        for (int i = 0; i < n; i++) begin
            ea = addr + AW'(i);
            chk({tag, "_sram_mem"}, {24'd0, sram_mem[ea]}, {24'd0, ref_mem[ea]});
        end
    endtask

    // mode: 0 = rd_ready always, 1 = pattern 1,0,0 repeating, 2 = random
    task automatic do_read(input logic [AW-1:0] addr, input int n, input int mode,
                           input string tag);
        int got = 0;
        int cyc = 0;
        int k = 0;
        logic r;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        logic [AW-1:0] ea;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = LW'(n - 1);
        #1;
        chk({tag, "_cmd_ready"}, {31'd0, bus_if.cmd_ready}, 32'd1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        // cyc 0 is the first READ cycle, which always issues
        while (got < n && cyc < 4000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus_if.rd_ready = r;
            #1;
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, {31'd0, bus_if.rd_valid}, 32'd1);
                chk({tag, "_stall_data"}, {24'd0, bus_if.rd_data}, {24'd0, prev_d});
                chk({tag, "_stall_last"}, {31'd0, bus_if.rd_last}, {31'd0, prev_l});
            end
            if (bus_if.rd_valid && r) begin
                ea = addr + AW'(got);
                chk({tag, "_rd_data"}, {24'd0, bus_if.rd_data}, {24'd0, ref_mem[ea]});
                chk({tag, "_rd_last"}, {31'd0, bus_if.rd_last}, (got == n - 1) ? 32'd1 : 32'd0);
                if (mode == 0) chk({tag, "_rd_cycle"}, cyc, got + 2);
                got++;
            end
            prev_stall = bus_if.rd_valid && !r;
            prev_d     = bus_if.rd_data;
            prev_l     = bus_if.rd_last;
            @(negedge clk);
            cyc++;
        end
        bus_if.rd_ready = 1'b0;
        chk({tag, "_rd_words"}, got, n);
        #1;
        while (bus_if.busy && k < 8) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_busy_end"}, {31'd0, bus_if.busy}, 32'd0);
        chk({tag, "_valid_end"}, {31'd0, bus_if.rd_valid}, 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int rn;
        reset            = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_len   = '0;
        bus_if.wr_valid  = 1'b0;
        bus_if.wr_data   = '0;
        bus_if.rd_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("idle_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        chk("idle_cs", {31'd0, sram_cs}, 32'd0);
        chk("idle_we", {31'd0, sram_we}, 32'd0);
        chk("idle_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);

        // Directed write with gapped wr_valid, then reads
        wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_write(16'h0010, 4, 1, "wr_gap");
        do_read(16'h0010, 4, 0, "rd_full");
        do_read(16'h0010, 4, 1, "rd_toggle");

        // Address wrap
        wq = '{8'h5A, 8'h5B, 8'h5C};
        do_write(16'hFFFF, 3, 0, "wr_wrap");
        do_read(16'hFFFF, 3, 0, "rd_wrap");
        chk("wrap_0000", {24'd0, ref_mem[16'h0000]}, 32'h5B);
        chk("wrap_0001", {24'd0, ref_mem[16'h0001]}, 32'h5C);

`ifdef SRAM_BURST_CTRL_PERF_EN
        chk("perf_wr", perf_wr_words, 32'd7);
        chk("perf_rd", perf_rd_words, 32'd11);
`endif

        // Randomized bursts
        for (int t = 0; t < 8; t++) begin
            ra = AW'($urandom);
            rn = $urandom_range(1, 12);
            wq = {};
            for (int i = 0; i < rn; i++) wq.push_back(DW'($urandom));
            do_write(ra, rn, 2, "wr_rand");
            do_read(ra, rn, 2, "rd_rand");
        end

        // Maximum-length burst
        ra = AW'($urandom);
        wq = {};
        for (int i = 0; i < 256; i++) wq.push_back(DW'($urandom));
        do_write(ra, 256, 0, "wr_max");
        do_read(ra, 256, 2, "rd_max");

        // Reset in the middle of a long read
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 16'h0010;
        bus_if.cmd_len   = 8'hFF;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        repeat (4) begin
            bus_if.rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus_if.rd_ready = 1'b0;
        #1;
        chk("pre_rst_busy", {31'd0, bus_if.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
        chk("mid_rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        chk("mid_rst_rd_last", {31'd0, bus_if.rd_last}, 32'd0);
        chk("mid_rst_wr_ready", {31'd0, bus_if.wr_ready}, 32'd0);
        chk("mid_rst_cs", {31'd0, sram_cs}, 32'd0);
        chk("mid_rst_we", {31'd0, sram_we}, 32'd0);
        chk("mid_rst_oe", {31'd0, sram_oe}, 32'd0);
        chk("mid_rst_addr", {16'd0, sram_addr}, 32'd0);
`ifdef SRAM_BURST_CTRL_PERF_EN
        chk("mid_rst_perf_wr", perf_wr_words, 32'd0);
        chk("mid_rst_perf_rd", perf_rd_words, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, bus_if.busy}, 32'd0);

        // Controller is usable again after the aborted burst
        do_read(16'h0010, 4, 0, "rd_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
Burst sequencer that sits directly upstream of the single_port_sram macro and is its only master. It accepts read/write burst commands over a valid/ready interface, streams write words in and read words out, and drives the SRAM's addr/cs/we/oe pins and the bidirectional data bus. PE-array weight loaders and activation writers talk to this block rather than to the SRAM.

Parameters:
ADDR_WIDTH, 16, SRAM address width; must equal the SRAM's ADDR_WIDTH
DATA_WIDTH, 8, word width; must equal the SRAM's DATA_WIDTH
LEN_WIDTH, 8, burst length field width; a burst is 1 to 2^LEN_WIDTH words

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  LEN_WIDTH  words minus 1
wr_valid  in  1  write word offered
wr_ready  out  1  write word accepted
wr_data  in  DATA_WIDTH  write word
rd_valid  out  1  read word available
rd_ready  in  1  downstream accepts read word
rd_data  out  DATA_WIDTH  read word
rd_last  out  1  marks the final word of a read burst
busy  out  1  high whenever state is not IDLE
sram_addr  out  ADDR_WIDTH  to SRAM addr
sram_data  inout  DATA_WIDTH  to SRAM data
sram_cs  out  1  chip select
sram_we  out  1  write enable
sram_oe  out  1  output enable

Behaviour:
- Reset (async, active-high): state=IDLE. All of the following go to 0: cmd_ready, wr_ready, rd_valid, rd_last, busy, sram_cs, sram_we, sram_oe, sram_addr. The read FIFO is flushed and sram_data is released to Z. A reset mid-burst aborts the burst and drops any in-flight words.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On handshake, latch addr and remaining count (cmd_len+1), then go to WRITE if cmd_write=1, else READ.
- WRITE:
  - wr_ready=1.
  - sram_cs = sram_we = wr_valid; sram_oe=0; sram_addr = current address.
  - sram_data is driven with wr_data only while sram_cs and sram_we are both high; otherwise it is Z.
  - On each accepted word: address +1, count -1. When the last word is accepted, go to IDLE.
- READ and DRAIN:
  - sram_cs=1, sram_we=0, sram_oe=1 on every cycle.
  - An issue happens in a cycle when count>0 and (FIFO occupancy + in-flight issues) < 2. On an issue, address +1 and count -1.
  - The SRAM word for an issue in cycle N appears on sram_data in cycle N+1. It is captured into a 2-entry read FIFO at the end of cycle N+1.
  - Non-issue cycles re-read harmlessly; captured data from those cycles is discarded.
  - When count reaches 0, go to DRAIN. DRAIN goes to IDLE once the FIFO is empty and nothing is in flight.
- Read output:
  - rd_valid = FIFO not empty; rd_data = FIFO head. Both are registered, so latency from issue to rd_valid is 2 cycles.
  - rd_last is set on the head entry that is the burst's final word.
  - rd_data/rd_valid/rd_last hold stable while rd_valid=1 and rd_ready=0.
  - With rd_ready held at 1, throughput is 1 word/cycle.
- Address wraps modulo 2^ADDR_WIDTH: 0xFFFF+1 = 0x0000 at the default width.
- cmd_len = 2^LEN_WIDTH-1 produces a 256-word burst at the default width.
- A new command is never accepted before the current burst fully completes. Read and write data interfaces are ignored in the non-matching state.
- The controller never drives sram_data while sram_oe=1.

Optional Feature:
SRAM_BURST_CTRL_PERF_EN.
- Defined: adds two outputs, perf_wr_words [31:0] and perf_rd_words [31:0].
  - perf_wr_words increments on each SRAM write cycle.
  - perf_rd_words increments on each rd_valid&rd_ready handshake.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: check busy=0, cmd_ready=1, sram_cs=0, sram_data=Z. Assert reset mid-read burst: all outputs return to reset values within the same cycle.
- Write burst addr=0x0010, len=3, data 0xA1..0xA4 with wr_valid gapped every other cycle -> SRAM holds 0xA1..0xA4 at 0x0010..0x0013; sram_cs is high only on the 4 data cycles.
- Read burst addr=0x0010, len=3, rd_ready=1 -> rd_data sequence 0xA1,0xA2,0xA3,0xA4 on 4 consecutive cycles, first one 2 cycles after the issue; rd_last only on 0xA4.
- Same read with rd_ready toggled 1,0,0,1,... -> no word lost or duplicated; rd_data stable while stalled; FIFO never exceeds 2 entries.
- Write 0x5A,0x5B,0x5C at addr=0xFFFF, len=2, then read back -> addresses 0xFFFF, 0x0000, 0x0001 return 0x5A, 0x5B, 0x5C.
- Under SRAM_BURST_CTRL_PERF_EN: after the scenarios above, perf_wr_words=7 and perf_rd_words=11.
